// File: rtl/pe_rf_mp_pkg.sv
// Shared index constants and index-classification helpers for the PE register file.
package pe_rf_mp_pkg;

  localparam int unsigned RF_ZERO_IDX     = 0;
  localparam int unsigned RF_ID_IDX       = 1;
  localparam int unsigned RF_FIRST_WR_IDX = 2;

  typedef enum logic [1:0] {
    IDX_ZERO,
    IDX_ID,
    IDX_WRITABLE,
    IDX_RESERVED
  } idx_class_e;

  function automatic int unsigned lastWrIdx(int unsigned depth, int unsigned resvTop);
    return depth - resvTop - 1;
  endfunction

  function automatic idx_class_e idxClass(int unsigned idx, int unsigned depth,
                                          int unsigned resvTop);
    if (idx == RF_ZERO_IDX)                 return IDX_ZERO;
    if (idx == RF_ID_IDX)                   return IDX_ID;
    if (idx > lastWrIdx(depth, resvTop))    return IDX_RESERVED;
    return IDX_WRITABLE;
  endfunction

  function automatic logic isWritable(int unsigned idx, int unsigned depth,
                                      int unsigned resvTop);
    return idxClass(idx, depth, resvTop) == IDX_WRITABLE;
  endfunction

endpackage

// File: rtl/pe_rf_mp_if.sv
// Read/lock/write bundle between ID, WB and the multi-port register file.
interface pe_rf_mp_if #(
  parameter int unsigned AW     = 5,
  parameter int unsigned DW     = 32,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned NUM_WR = 1
);
  logic [NUM_RD*AW-1:0] iIF_RF_Read_Addr;
  logic [NUM_RD*DW-1:0] oRF_BP_Read_Data;
  logic [NUM_RD-1:0]    oRF_ID_Pending;
  logic [AW-1:0]        iID_RF_Lock_Addr;
  logic                 iID_RF_Lock_Enable;
  logic [NUM_WR*AW-1:0] iWB_RF_Write_Addr;
  logic [NUM_WR*DW-1:0] iWB_RF_Write_Data;
  logic [NUM_WR-1:0]    iWB_RF_Write_Enable;

  modport master (
    output iIF_RF_Read_Addr, iID_RF_Lock_Addr, iID_RF_Lock_Enable,
           iWB_RF_Write_Addr, iWB_RF_Write_Data, iWB_RF_Write_Enable,
    input  oRF_BP_Read_Data, oRF_ID_Pending
  );

  modport slave (
    input  iIF_RF_Read_Addr, iID_RF_Lock_Addr, iID_RF_Lock_Enable,
           iWB_RF_Write_Addr, iWB_RF_Write_Data, iWB_RF_Write_Enable,
    output oRF_BP_Read_Data, oRF_ID_Pending
  );
endinterface

// File: rtl/pe_rf_scoreboard.sv
// Pending-write scoreboard: one bit per writable index, set by lock, cleared by write.
module pe_rf_scoreboard
  import pe_rf_mp_pkg::*;
#(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned RESV_TOP = 4
) (
  input  logic                 iClk,
  input  logic                 iRst_N,
  input  logic [AW-1:0]        lockAddr,
  input  logic                 lockEn,
  input  logic [NUM_WR*AW-1:0] wrAddr,
  input  logic [NUM_WR-1:0]    wrEn,
  input  logic [NUM_RD*AW-1:0] rdAddr,
  output logic [NUM_RD-1:0]    pending
);

  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pendNxt;
  logic [DEPTH-1:0] wrMask;

  always_comb begin
    wrMask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wrMask[i] = isWritable(i, DEPTH, RESV_TOP);
    end
  end

  // Clears are applied before the lock so a same-cycle lock (new producer) wins.
  always_comb begin
    pendNxt = pend;
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      if (wrEn[w]) pendNxt[wrAddr[w*AW +: AW]] = 1'b0;
    end
    if (lockEn) pendNxt[lockAddr] = 1'b1;
    pendNxt = pendNxt & wrMask;
  end

  always_ff @(posedge iClk) begin
    if (!iRst_N) pend <= '0;
    else         pend <= pendNxt;
  end

  always_comb begin
    pending = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      logic [AW-1:0] a;
      logic          wrHit;
      a     = rdAddr[k*AW +: AW];
      wrHit = 1'b0;
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if ((BYPASS != 0) && wrEn[w] && (wrAddr[w*AW +: AW] == a)) wrHit = 1'b1;
      end
      pending[k] = pend[a] & wrMask[a] & ~wrHit;
    end
  end

endmodule

// File: rtl/pe_rf_mp.sv
// Parametrised multi-port PE register file with optional write bypass and pending scoreboard.
module pe_rf_mp
  import pe_rf_mp_pkg::*;
#(
  parameter int unsigned                Para_DATA_WIDTH = 32,
  parameter logic [Para_DATA_WIDTH-1:0] Para_PE_ID      = '0,
  parameter int unsigned                Para_DEPTH      = 32,
  parameter int unsigned                Para_NUM_RD     = 2,
  parameter int unsigned                Para_NUM_WR     = 1,
  parameter int unsigned                Para_BYPASS     = 1,
  parameter int unsigned                Para_RESV_TOP   = 4
) (
  input  logic     iClk,
  input  logic     iRst_N,
  pe_rf_mp_if.slave rfIf
);

  localparam int unsigned DW = Para_DATA_WIDTH;
  localparam int unsigned AW = $clog2(Para_DEPTH);

  logic [DW-1:0]         entryVal [Para_DEPTH];
  logic [Para_DEPTH-1:0] wrMask;

  always_comb begin
    wrMask = '0;
    for (int unsigned i = 0; i < Para_DEPTH; i++) begin
      wrMask[i] = isWritable(i, Para_DEPTH, Para_RESV_TOP);
    end
  end

  genvar g;
  generate
    for (g = 0; g < Para_DEPTH; g++) begin : gEntry
      localparam idx_class_e CLS = idxClass(g, Para_DEPTH, Para_RESV_TOP);
      if (CLS == IDX_WRITABLE) begin : gWr
        localparam logic [AW-1:0] IDX = AW'(g);
        logic [DW-1:0] q;
        logic [DW-1:0] d;
        // Ascending scan: the highest-numbered enabled port wins a collision.
        always_comb begin
          d = q;
          for (int unsigned w = 0; w < Para_NUM_WR; w++) begin
            if (rfIf.iWB_RF_Write_Enable[w] && (rfIf.iWB_RF_Write_Addr[w*AW +: AW] == IDX))
              d = rfIf.iWB_RF_Write_Data[w*DW +: DW];
          end
        end
        always_ff @(posedge iClk) begin
          if (!iRst_N) q <= '0;
          else         q <= d;
        end
        assign entryVal[g] = q;
      end else if (CLS == IDX_ID) begin : gId
        assign entryVal[g] = Para_PE_ID;
      end else begin : gConst
        assign entryVal[g] = '0;
      end
    end

    for (g = 0; g < Para_NUM_RD; g++) begin : gRd
      logic [AW-1:0] a;
      logic [DW-1:0] rd;
      assign a = rfIf.iIF_RF_Read_Addr[g*AW +: AW];
      always_comb begin
        rd = entryVal[a];
        if ((Para_BYPASS != 0) && wrMask[a]) begin
          for (int unsigned w = 0; w < Para_NUM_WR; w++) begin
            if (rfIf.iWB_RF_Write_Enable[w] && (rfIf.iWB_RF_Write_Addr[w*AW +: AW] == a))
              rd = rfIf.iWB_RF_Write_Data[w*DW +: DW];
          end
        end
      end
      assign rfIf.oRF_BP_Read_Data[g*DW +: DW] = rd;
    end
  endgenerate

  pe_rf_scoreboard #(
    .DEPTH    (Para_DEPTH),
    .AW       (AW),
    .NUM_RD   (Para_NUM_RD),
    .NUM_WR   (Para_NUM_WR),
    .BYPASS   (Para_BYPASS),
    .RESV_TOP (Para_RESV_TOP)
  ) uScoreboard (
    .iClk     (iClk),
    .iRst_N   (iRst_N),
    .lockAddr (rfIf.iID_RF_Lock_Addr),
    .lockEn   (rfIf.iID_RF_Lock_Enable),
    .wrAddr   (rfIf.iWB_RF_Write_Addr),
    .wrEn     (rfIf.iWB_RF_Write_Enable),
    .rdAddr   (rfIf.iIF_RF_Read_Addr),
    .pending  (rfIf.oRF_ID_Pending)
  );

endmodule

// File: tb/tb_pe_rf_mp.sv
// Directed-vector bench: bypassing 2-write RF driven from a table, non-bypassing 1-write RF by hand.
module tb_pe_rf_mp;

  logic iClk = 1'b0;
  logic rstB = 1'b0;
  logic rstN = 1'b0;
  int unsigned nApplied = 0;
  int unsigned nMiss    = 0;

  always #5 iClk = ~iClk;

  pe_rf_mp_if #(.AW(5), .DW(32), .NUM_RD(2), .NUM_WR(2)) ifB ();
  pe_rf_mp_if #(.AW(5), .DW(32), .NUM_RD(2), .NUM_WR(1)) ifN ();

  pe_rf_mp #(
    .Para_DATA_WIDTH(32), .Para_PE_ID(32'h5), .Para_DEPTH(32), .Para_NUM_RD(2),
    .Para_NUM_WR(2), .Para_BYPASS(1), .Para_RESV_TOP(4)
  ) dutB (.iClk(iClk), .iRst_N(rstB), .rfIf(ifB.slave));

  pe_rf_mp #(
    .Para_DATA_WIDTH(32), .Para_PE_ID(32'h5), .Para_DEPTH(32), .Para_NUM_RD(2),
    .Para_NUM_WR(1), .Para_BYPASS(0), .Para_RESV_TOP(4)
  ) dutN (.iClk(iClk), .iRst_N(rstN), .rfIf(ifN.slave));

  typedef struct {
    bit          rst;
    bit [1:0]    we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    bit          le;
    logic [4:0]  la;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    bit          ep0;
    bit          ep1;
  } vec_t;

  vec_t vecs[$];

  task automatic add(bit rst, bit [1:0] we, logic [4:0] wa0, logic [31:0] wd0,
                     logic [4:0] wa1, logic [31:0] wd1, bit le, logic [4:0] la,
                     logic [4:0] ra0, logic [4:0] ra1, logic [31:0] e0, logic [31:0] e1,
                     bit ep0, bit ep1);
    vec_t v;
    v.rst = rst; v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.le = le; v.la = la; v.ra0 = ra0; v.ra1 = ra1; v.e0 = e0; v.e1 = e1;
    v.ep0 = ep0; v.ep1 = ep1;
    vecs.push_back(v);
  endtask

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    nApplied++;
    if (act !== exp) begin
      nMiss++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic driveN(bit rst, bit we, logic [4:0] wa, logic [31:0] wd, bit le,
                        logic [4:0] la, logic [4:0] ra0, logic [4:0] ra1);
    @(negedge iClk);
    rstN = rst;
    ifN.iWB_RF_Write_Enable = we;
    ifN.iWB_RF_Write_Addr   = wa;
    ifN.iWB_RF_Write_Data   = wd;
    ifN.iID_RF_Lock_Enable  = le;
    ifN.iID_RF_Lock_Addr    = la;
    ifN.iIF_RF_Read_Addr    = {ra1, ra0};
    #2;
  endtask

  initial begin
    ifB.iIF_RF_Read_Addr = '0; ifB.iID_RF_Lock_Addr = '0; ifB.iID_RF_Lock_Enable = 1'b0;
    ifB.iWB_RF_Write_Addr = '0; ifB.iWB_RF_Write_Data = '0; ifB.iWB_RF_Write_Enable = '0;
    ifN.iIF_RF_Read_Addr = '0; ifN.iID_RF_Lock_Addr = '0; ifN.iID_RF_Lock_Enable = 1'b0;
    ifN.iWB_RF_Write_Addr = '0; ifN.iWB_RF_Write_Data = '0; ifN.iWB_RF_Write_Enable = '0;

    //  rst we    wa0 wd0            wa1 wd1            le la  ra0 ra1 e0             e1             p0 p1
    add(0, 2'b00, 0,  0,             0,  0,             0, 0,  0,  1,  0,             32'h5,         0, 0);
    add(1, 2'b00, 0,  0,             0,  0,             0, 0,  2,  27, 0,             0,             0, 0);
    add(1, 2'b00, 0,  0,             0,  0,             0, 0,  28, 31, 0,             0,             0, 0);
    add(1, 2'b00, 0,  0,             0,  0,             0, 0,  15, 1,  0,             32'h5,         0, 0);
    add(1, 2'b01, 7,  32'hDEADBEEF,  0,  0,             0, 0,  7,  7,  32'hDEADBEEF,  32'hDEADBEEF,  0, 0);
    add(1, 2'b00, 0,  0,             0,  0,             0, 0,  7,  0,  32'hDEADBEEF,  0,             0, 0);
    add(1, 2'b11, 0,  32'hFFFFFFFF,  1,  32'hFFFFFFFF,  0, 0,  0,  1,  0,             32'h5,         0, 0);
    add(1, 2'b01, 29, 32'hFFFFFFFF,  0,  0,             0, 0,  29, 0,  0,             0,             0, 0);
    add(1, 2'b00, 0,  0,             0,  0,             0, 0,  0,  1,  0,             32'h5,         0, 0);
    add(1, 2'b00, 0,  0,             0,  0,             0, 0,  29, 28, 0,             0,             0, 0);
    add(1, 2'b11, 5,  32'h1,         5,  32'h2,         0, 0,  5,  5,  32'h2,         32'h2,         0, 0);
    add(1, 2'b00, 0,  0,             0,  0,             0, 0,  5,  7,  32'h2,         32'hDEADBEEF,  0, 0);
    add(1, 2'b00, 0,  0,             0,  0,             1, 9,  9,  9,  0,             0,             0, 0);
    add(1, 2'b00, 0,  0,             0,  0,             0, 0,  9,  5,  0,             32'h2,         1, 0);
    add(1, 2'b01, 9,  32'h99,        0,  0,             0, 0,  9,  9,  32'h99,        32'h99,        0, 0);
    add(1, 2'b00, 0,  0,             0,  0,             0, 0,  9,  5,  32'h99,        32'h2,         0, 0);
    add(1, 2'b10, 0,  0,             9,  32'h77,        1, 9,  9,  9,  32'h77,        32'h77,        0, 0);
    add(1, 2'b00, 0,  0,             0,  0,             0, 0,  9,  9,  32'h77,        32'h77,        1, 1);
    add(1, 2'b00, 0,  0,             0,  0,             1, 29, 29, 9,  0,             32'h77,        0, 1);
    add(1, 2'b00, 0,  0,             0,  0,             0, 0,  29, 9,  0,             32'h77,        0, 1);
    add(1, 2'b01, 12, 32'hA5A5,      0,  0,             1, 12, 12, 9,  32'hA5A5,      32'h77,        0, 1);
    add(1, 2'b00, 0,  0,             0,  0,             0, 0,  12, 7,  32'hA5A5,      32'hDEADBEEF,  1, 0);
    add(0, 2'b01, 12, 32'h1,         0,  0,             0, 0,  9,  1,  32'h77,        32'h5,         1, 0);
    add(1, 2'b00, 0,  0,             0,  0,             0, 0,  12, 9,  0,             0,             0, 0);
    add(1, 2'b00, 0,  0,             0,  0,             0, 0,  7,  5,  0,             0,             0, 0);
    add(1, 2'b11, 27, 32'h1B,        2,  32'h22,        0, 0,  2,  27, 32'h22,        32'h1B,        0, 0);
    add(1, 2'b00, 0,  0,             0,  0,             0, 0,  2,  27, 32'h22,        32'h1B,        0, 0);
    add(1, 2'b01, 2,  32'h33,        0,  0,             1, 27, 27, 2,  32'h1B,        32'h33,        0, 0);
    add(1, 2'b00, 0,  0,             0,  0,             0, 0,  27, 2,  32'h1B,        32'h33,        1, 0);

    foreach (vecs[i]) begin
      @(negedge iClk);
      rstB = vecs[i].rst;
      ifB.iWB_RF_Write_Enable = vecs[i].we;
      ifB.iWB_RF_Write_Addr   = {vecs[i].wa1, vecs[i].wa0};
      ifB.iWB_RF_Write_Data   = {vecs[i].wd1, vecs[i].wd0};
      ifB.iID_RF_Lock_Enable  = vecs[i].le;
      ifB.iID_RF_Lock_Addr    = vecs[i].la;
      ifB.iIF_RF_Read_Addr    = {vecs[i].ra1, vecs[i].ra0};
      #2;
      chk("byp_rd0",  i, ifB.oRF_BP_Read_Data[31:0],  vecs[i].e0);
      chk("byp_rd1",  i, ifB.oRF_BP_Read_Data[63:32], vecs[i].e1);
      chk("byp_pnd0", i, 32'(ifB.oRF_ID_Pending[0]),  32'(vecs[i].ep0));
      chk("byp_pnd1", i, 32'(ifB.oRF_ID_Pending[1]),  32'(vecs[i].ep1));
    end
    @(negedge iClk);
    ifB.iWB_RF_Write_Enable = '0;
    ifB.iID_RF_Lock_Enable  = 1'b0;

    // Non-bypassing instance: writes appear only a cycle later and do not mask pending.
    driveN(0, 0, 0,  0,            0, 0, 1, 7);
    chk("nb_reset_id", 100, ifN.oRF_BP_Read_Data[31:0], 32'h5);
    chk("nb_reset_pnd", 100, 32'(ifN.oRF_ID_Pending), 32'h0);
    driveN(1, 1, 7,  32'hDEADBEEF, 0, 0, 7, 1);
    chk("nb_wr_same", 101, ifN.oRF_BP_Read_Data[31:0], 32'h0);
    chk("nb_id", 101, ifN.oRF_BP_Read_Data[63:32], 32'h5);
    driveN(1, 0, 0,  0,            0, 0, 7, 0);
    chk("nb_wr_next", 102, ifN.oRF_BP_Read_Data[31:0], 32'hDEADBEEF);
    driveN(1, 0, 0,  0,            1, 9, 9, 9);
    chk("nb_lock_same", 103, 32'(ifN.oRF_ID_Pending), 32'h0);
    driveN(1, 1, 9,  32'h1,        0, 0, 9, 9);
    chk("nb_clr_data", 104, ifN.oRF_BP_Read_Data[31:0], 32'h0);
    chk("nb_clr_pnd", 104, 32'(ifN.oRF_ID_Pending), 32'h3);
    driveN(1, 0, 0,  0,            0, 0, 9, 7);
    chk("nb_after_data", 105, ifN.oRF_BP_Read_Data[31:0], 32'h1);
    chk("nb_after_pnd", 105, 32'(ifN.oRF_ID_Pending), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
    $finish;
  end

endmodule

// File: doc/pe_rf_mp.md
# pe_rf_mp

Parametrised multi-port register file for the PE datapath; successor to the fixed 2-read/1-write, 32×32 PE register file. It provides a configurable number of read and write ports, an optional same-cycle write-to-read bypass, and a pending-write scoreboard so the ID stage can stall on long-latency results. It sits between the IF/ID read-address path, the bypass network and the WB stage(s).

## Interface
- Para_PE_ID, 32'h0, value returned when index 1 is read.
- Para_DATA_WIDTH, 32, width of each entry.
- Para_DEPTH, 32, number of architectural indices (power of two, ≥8); AW = clog2(Para_DEPTH).
- Para_NUM_RD, 2, number of read ports (1–4).
- Para_NUM_WR, 1, number of write ports (1–2).
- Para_BYPASS, 1, 1 = same-cycle write data forwarded to reads.
- Para_RESV_TOP, 4, number of top indices reserved for comm ports; they read 0 and ignore writes.
- iClk  in  1  system clock, posedge.
- iRst_N  in  1  synchronous, active-low reset.
- iIF_RF_Read_Addr  in  NUM_RD*AW  packed read addresses; port k occupies bits [k*AW +: AW].
- oRF_BP_Read_Data  out  NUM_RD*DATA_WIDTH  packed read data.
- oRF_ID_Pending  out  NUM_RD  port k's address has an outstanding locked write.
- iID_RF_Lock_Addr  in  AW  index to mark pending.
- iID_RF_Lock_Enable  in  1  set the pending bit for iID_RF_Lock_Addr.
- iWB_RF_Write_Addr  in  NUM_WR*AW  packed write addresses.
- iWB_RF_Write_Data  in  NUM_WR*DATA_WIDTH  packed write data.
- iWB_RF_Write_Enable  in  NUM_WR  per-port write enable.

## Operation
- Writable range: indices 2 .. DEPTH-RESV_TOP-1. Writes to 0, 1 or reserved indices are silently dropped; no storage is modified.
- Reads: index 0 → 0; index 1 → Para_PE_ID; reserved → 0; else stored entry.
- Write collision: both write ports enabled to the same index → port NUM_WR-1 wins.
- Bypass (Para_BYPASS=1): if an enabled write port targets a writable index equal to read address k, output k returns that write data, applying the same collision priority. Para_BYPASS=0: reads return the pre-write value.
- Scoreboard: one pending bit per writable index. Lock sets the bit; any enabled write to that index clears it. Simultaneous lock and write to the same index leaves the bit set, because lock wins (new producer). A lock to a non-writable index is ignored.
- oRF_ID_Pending[k] = pending[addr_k] AND NOT (Para_BYPASS AND a write to addr_k in this cycle). For non-writable indices it is always 0.
- Reset (iRst_N=0 at a posedge): all entries ← 0, all pending ← 0. Writes and locks in the same cycle are discarded. Read outputs stay combinational during reset.

## Timing
- Read data and pending are combinational from addresses/state; there is no read latency.
- Write: committed at the posedge; visible on non-bypassed reads from the next cycle.
- Lock: pending visible from the cycle after iID_RF_Lock_Enable.
- Write clears pending: visible the next cycle, or the same cycle via the mask when bypass is on.
- Reset values: storage 0, pending 0. Outputs follow: reads of index 1 show Para_PE_ID and all other indices show 0; oRF_ID_Pending = 0.

## Structure
- Add to def-pe.v: DEF_RF_ZERO_IDX (0), DEF_RF_ID_IDX (1), DEF_RF_FIRST_WR_IDX (2), plus a helper macro for the last writable index from depth and RESV_TOP.
- Storage and read muxes use generate loops over DEPTH and NUM_RD; no hand-unrolled cases.
- One sub-module: pe_rf_scoreboard. It holds the pending-bit vector and the lock/clear/priority logic, and has NUM_RD lookup outputs.

## Test plan
- Reset then read all indices → 0 everywhere except index 1 = Para_PE_ID (e.g. 32'h5); pending all 0.
- Write 32'hDEAD_BEEF to r7, read r7 on port 0 the same cycle → with BYPASS=1 returns DEAD_BEEF; with BYPASS=0 returns 0 that cycle and DEAD_BEEF the next.
- Writes to r0, r1 and r29 (DEPTH=32, RESV_TOP=4) with data 32'hFFFF_FFFF → reads remain 0, PE_ID and 0.
- NUM_WR=2: port 0 writes 32'h1 and port 1 writes 32'h2 to r5 in the same cycle → r5 = 32'h2; the bypassed read also returns 32'h2.
- Lock r9 → pending[9] reads 1 next cycle. Write r9 → pending 0 (same cycle with BYPASS=1). Lock and write r9 in the same cycle → pending stays 1.
- Write r12 = 32'hA5A5 and lock r12, then hold iRst_N=0 one cycle while a write to r12 = 32'h1 is presented → r12 = 0 and pending[12] = 0 after reset.
